// File: rtl/spec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spec_ctrl_pkg
//  Description : Shared types and default sizes for the speculative commit
//                controller: entry-state encoding, entry record and a small
//                state helper used by the tag lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package spec_ctrl_pkg;

    localparam int c_default_depth  = 4;
    localparam int c_default_tag_w  = 4;
    localparam int c_default_data_w = 8;

    // FREE must stay the all-zero code so a cleared entry reads as empty.
    typedef enum logic [1:0] {
        FREE = 2'd0,
        SPEC = 2'd1,
        SAFE = 2'd2
    } entry_state_e;

    typedef struct packed {
        entry_state_e                state;
        logic [c_default_tag_w-1:0]  tag;
        logic [c_default_data_w-1:0] data;
    } entry_t;

    function automatic logic is_spec(input entry_state_e s);
        return (s == SPEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spec_tag_match.sv
`default_nettype none
// ============================================================================
//  Module      : spec_tag_match
//  Description : Combinational age-ordered tag lookup. Scans the circular
//                entry array starting at the head (oldest) and reports the
//                oldest SPEC entry whose tag equals the resolve tag.
//  Ports       : i_entry_state / i_entry_tag - per-entry state and tag
//                i_head      - index of the oldest entry
//                i_l_status  - tag being resolved
//                o_hit       - a SPEC entry with that tag exists
//                o_match_idx - index of the oldest such entry
//  Revision    : 1.0 - initial release
// ============================================================================
module spec_tag_match
    import spec_ctrl_pkg::*;
#(
    parameter int DEPTH = c_default_depth,
    parameter int TAG_W = c_default_tag_w
) (
    input  entry_state_e                 i_entry_state [DEPTH],
    input  logic [TAG_W-1:0]             i_entry_tag   [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     i_head,
    input  logic [TAG_W-1:0]             i_l_status,
    output logic                         o_hit,
    output logic [$clog2(DEPTH)-1:0]     o_match_idx
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w-1:0] w_idx;

    // Walk from youngest to oldest so the oldest match is the last writer
    // and therefore wins. Index arithmetic wraps because DEPTH is 2**n.
    always_comb begin
        o_hit       = 1'b0;
        o_match_idx = '0;
        w_idx       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_idx = i_head + c_ptr_w'(i);
            if (is_spec(i_entry_state[w_idx]) && (i_entry_tag[w_idx] == i_l_status)) begin
                o_hit       = 1'b1;
                o_match_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spec_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spec_commit_ctrl
//  Description : Holds up to DEPTH tagged speculative entries in age order,
//                resolves them by tag from the status bus, commits confirmed
//                entries in order and flushes misspeculated entries together
//                with everything younger. Speculative payload never appears
//                on the commit outputs.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                alloc_valid/ready/tag/data - producer side
//                l_valid/l_status/l_squash  - resolution bus
//                commit_valid/ready/data/tag - in-order commit port
//                busy                  - any entry live
//                squash_cnt            - saturating squash-event count
//  Config      : SPEC_SQUASH_CNT_EN - when defined, squash_cnt counts
//                matching squash events (saturating at 255); otherwise it
//                is tied to zero and no counter exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module spec_commit_ctrl
    import spec_ctrl_pkg::*;
#(
    parameter int DEPTH  = c_default_depth,
    parameter int TAG_W  = c_default_tag_w,
    parameter int DATA_W = c_default_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [DATA_W-1:0] alloc_data,
    input  logic              l_valid,
    input  logic [TAG_W-1:0]  l_status,
    input  logic              l_squash,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              busy,
    output logic [7:0]        squash_cnt
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    entry_state_e        r_state [DEPTH];
    logic [TAG_W-1:0]    r_tag   [DEPTH];
    logic [DATA_W-1:0]   r_data  [DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_hit;
    logic [c_ptr_w-1:0]  w_match_idx;
    logic [c_ptr_w-1:0]  w_match_off;
    logic [DEPTH-1:0]    w_younger;
    logic [c_ptr_w-1:0]  w_off;
    logic                w_alloc_fire;
    logic                w_confirm;
    logic                w_squash;
    logic                w_commit;

    spec_tag_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_match (
        .i_entry_state (r_state),
        .i_entry_tag   (r_tag),
        .i_head        (r_head),
        .i_l_status    (l_status),
        .o_hit         (w_hit),
        .o_match_idx   (w_match_idx)
    );

    // A squash in flight may move the tail backwards, so allocation is held
    // off for that cycle rather than racing it.
    assign alloc_ready  = (r_count < c_cnt_w'(DEPTH)) && !(l_valid && l_squash);
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_confirm    = l_valid && !l_squash && w_hit;
    assign w_squash     = l_valid &&  l_squash && w_hit;

    // Commit side is a pure function of registered state.
    assign commit_valid = (r_state[r_head] == SAFE);
    assign commit_data  = commit_valid ? r_data[r_head] : '0;
    assign commit_tag   = commit_valid ? r_tag[r_head]  : '0;
    assign w_commit     = commit_valid && commit_ready;
    assign busy         = (r_count != '0);

    // Age of the matched entry relative to head; every slot at that age or
    // greater is the squashed entry or younger. Slots beyond the live count
    // are already FREE, so including them is harmless.
    assign w_match_off = w_match_idx - r_head;

    always_comb begin
        w_younger = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off        = c_ptr_w'(i) - r_head;
            w_younger[i] = (w_off >= w_match_off);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= FREE;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // The four per-slot updates never target the same slot in one
            // cycle: alloc hits a FREE slot, confirm a SPEC slot, commit the
            // SAFE head, and squash never coexists with alloc.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (r_tail == c_ptr_w'(i))) begin
                    r_state[i] <= SPEC;
                    r_tag[i]   <= alloc_tag;
                    r_data[i]  <= alloc_data;
                end
                if (w_confirm && (w_match_idx == c_ptr_w'(i))) begin
                    r_state[i] <= SAFE;
                end
                if ((w_commit && (r_head == c_ptr_w'(i))) || (w_squash && w_younger[i])) begin
                    r_state[i] <= FREE;
                    r_tag[i]   <= '0;
                    r_data[i]  <= '0;
                end
            end

            if (w_commit) begin
                r_head <= r_head + c_ptr_w'(1);
            end

            if (w_squash) begin
                r_tail <= w_match_idx;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end

            // After a squash only the entries older than the match survive,
            // minus the head if it commits in the same cycle.
            if (w_squash) begin
                r_count <= c_cnt_w'(w_match_off) - c_cnt_w'(w_commit);
            end else begin
                r_count <= r_count + c_cnt_w'(w_alloc_fire) - c_cnt_w'(w_commit);
            end
        end
    end

`ifdef SPEC_SQUASH_CNT_EN
    logic [7:0] r_squash_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_squash_cnt <= 8'd0;
        end else if (w_squash && (r_squash_cnt != 8'hFF)) begin
            r_squash_cnt <= r_squash_cnt + 8'd1;
        end
    end

    assign squash_cnt = r_squash_cnt;
`else
    assign squash_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spec_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spec_commit_ctrl
//  Description : Directed self-checking bench for spec_commit_ctrl at the
//                default sizes (DEPTH=4, TAG_W=4, DATA_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spec_commit_ctrl;

`ifdef SPEC_SQUASH_CNT_EN
    localparam bit c_cnt_en = 1'b1;
`else
    localparam bit c_cnt_en = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic [7:0] alloc_data;
    logic       l_valid;
    logic [3:0] l_status;
    logic       l_squash;
    logic       commit_valid;
    logic       commit_ready;
    logic [7:0] commit_data;
    logic [3:0] commit_tag;
    logic       busy;
    logic [7:0] squash_cnt;

    int total;
    int bad;
    int exp_sq;
    int exp_cv;

    spec_commit_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .alloc_data   (alloc_data),
        .l_valid      (l_valid),
        .l_status     (l_status),
        .l_squash     (l_squash),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .busy         (busy),
        .squash_cnt   (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [3:0] t, input logic [7:0] d);
        alloc_valid = 1'b1;
        alloc_tag   = t;
        alloc_data  = d;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic [3:0] t, input logic sq);
        l_valid  = 1'b1;
        l_status = t;
        l_squash = sq;
        tick();
        l_valid  = 1'b0;
        l_squash = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_sq = 0;
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_tag = '0; alloc_data = '0;
        l_valid = 1'b0; l_status = '0; l_squash = 1'b0;
        commit_ready = 1'b0;
        tick(); tick();

        // ---- reset state ----
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_commit_data", 32'(commit_data), 0);
        chk("rst_commit_tag", 32'(commit_tag), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_squash_cnt", 32'(squash_cnt), 0);
        rst_n = 1'b1;
        tick();

        // ---- in-order commit with out-of-order confirms ----
        do_alloc(4'd1, 8'h11);
        do_alloc(4'd2, 8'h22);
        do_alloc(4'd3, 8'h33);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_all_spec_cv", 32'(commit_valid), 0);
        do_resolve(4'd2, 1'b0);
        chk("t1_head_spec_cv", 32'(commit_valid), 0);
        commit_ready = 1'b1;
        do_resolve(4'd1, 1'b0);
        chk("t1_c1_cv", 32'(commit_valid), 1);
        chk("t1_c1_data", 32'(commit_data), 32'h11);
        chk("t1_c1_tag", 32'(commit_tag), 1);
        tick();
        chk("t1_c2_cv", 32'(commit_valid), 1);
        chk("t1_c2_data", 32'(commit_data), 32'h22);
        chk("t1_c2_tag", 32'(commit_tag), 2);
        tick();
        chk("t1_hold3_cv", 32'(commit_valid), 0);
        chk("t1_hold3_data", 32'(commit_data), 0);
        chk("t1_hold3_tag", 32'(commit_tag), 0);
        tick();
        chk("t1_hold3_cv2", 32'(commit_valid), 0);
        do_resolve(4'd3, 1'b0);
        chk("t1_c3_data", 32'(commit_data), 32'h33);
        tick();
        chk("t1_empty_busy", 32'(busy), 0);
        commit_ready = 1'b0;

        // ---- full, then squash middle entry ----
        do_reset();
        do_alloc(4'd1, 8'hA1);
        do_alloc(4'd2, 8'hA2);
        do_alloc(4'd3, 8'hA3);
        do_alloc(4'd4, 8'hA4);
        alloc_valid = 1'b1; alloc_tag = 4'd5; alloc_data = 8'hA5;
        #1;
        chk("t2_full_ready", 32'(alloc_ready), 0);
        tick();
        alloc_valid = 1'b0;
        do_resolve(4'd2, 1'b1);
        exp_sq = c_cnt_en ? 1 : 0;
        #1;
        chk("t2_after_squash_ready", 32'(alloc_ready), 1);
        chk("t2_squash_cnt", 32'(squash_cnt), 32'(exp_sq));
        chk("t2_busy", 32'(busy), 1);
        do_alloc(4'd8, 8'h88);
        do_alloc(4'd9, 8'h99);
        #1;
        chk("t2_cnt3_ready", 32'(alloc_ready), 1);
        do_alloc(4'd10, 8'hAA);
        #1;
        chk("t2_refull_ready", 32'(alloc_ready), 0);

        // ---- resolve of absent tag, both polarities ----
        do_resolve(4'd7, 1'b0);
        do_resolve(4'd7, 1'b1);
        chk("t3_absent_sq_cnt", 32'(squash_cnt), 32'(exp_sq));
        chk("t3_absent_cv", 32'(commit_valid), 0);
        chk("t3_absent_full", 32'(alloc_ready), 0);
        do_resolve(4'd1, 1'b0);
        chk("t3_c1_data", 32'(commit_data), 32'hA1);
        chk("t3_c1_tag", 32'(commit_tag), 1);
        commit_ready = 1'b1;
        tick();
        chk("t3_next_spec_cv", 32'(commit_valid), 0);
        chk("t3_cnt3_ready", 32'(alloc_ready), 1);
        l_valid = 1'b1; l_squash = 1'b1; l_status = 4'd7;
        #1;
        chk("t3_squash_gates_alloc", 32'(alloc_ready), 0);
        l_valid = 1'b0; l_squash = 1'b0;
        #1;
        do_resolve(4'd8, 1'b0);
        chk("t3_c8_data", 32'(commit_data), 32'h88);
        do_resolve(4'd9, 1'b0);
        chk("t3_c9_data", 32'(commit_data), 32'h99);
        do_resolve(4'd10, 1'b0);
        chk("t3_c10_data", 32'(commit_data), 32'hAA);
        tick();
        chk("t3_drained_busy", 32'(busy), 0);
        chk("t3_drained_cv", 32'(commit_valid), 0);

        // ---- pipelined alloc/confirm/commit across pointer wrap ----
        for (int k = 0; k < 12; k++) begin
            alloc_valid = (k < 10);
            alloc_tag   = 4'(k + 1);
            alloc_data  = 8'(8'h40 + k);
            l_valid     = (k >= 1) && (k <= 10);
            l_status    = 4'(k);
            l_squash    = 1'b0;
            tick();
            exp_cv = ((k >= 1) && (k <= 10)) ? 1 : 0;
            chk("t4_wrap_cv", 32'(commit_valid), 32'(exp_cv));
            chk("t4_wrap_data", 32'(commit_data), (exp_cv != 0) ? 32'(32'h40 + k - 1) : 32'h0);
        end
        alloc_valid = 1'b0;
        l_valid = 1'b0;
        chk("t4_busy", 32'(busy), 0);

        // ---- same-cycle confirm and commit ----
        commit_ready = 1'b0;
        do_alloc(4'd4, 8'hD4);
        do_alloc(4'd5, 8'hD5);
        do_resolve(4'd4, 1'b0);
        chk("t5_head4_tag", 32'(commit_tag), 4);
        commit_ready = 1'b1;
        do_resolve(4'd5, 1'b0);
        chk("t5_next_cv", 32'(commit_valid), 1);
        chk("t5_next_tag", 32'(commit_tag), 5);
        chk("t5_next_data", 32'(commit_data), 32'hD5);
        tick();
        chk("t5_busy", 32'(busy), 0);
        commit_ready = 1'b0;

        // ---- asynchronous reset mid-operation ----
        do_alloc(4'd1, 8'h51);
        do_alloc(4'd2, 8'h52);
        do_alloc(4'd3, 8'h53);
        do_resolve(4'd1, 1'b0);
        chk("t6_pre_cv", 32'(commit_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_cv", 32'(commit_valid), 0);
        chk("t6_async_data", 32'(commit_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_sq_cleared", 32'(squash_cnt), 0);

        // ---- squash counter saturation ----
        for (int n = 0; n < 300; n++) begin
            do_alloc(4'd6, 8'h66);
            do_resolve(4'd6, 1'b1);
        end
        chk("t7_sq_sat", 32'(squash_cnt), c_cnt_en ? 32'd255 : 32'd0);
        chk("t7_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spec_commit_ctrl.md
# spec_commit_ctrl

Controller that sequences speculative data from producers into the committed, non-speculative domain. It holds up to DEPTH tagged entries in age order and resolves each one by tag from the status bus (`l_valid`/`l_status`/`l_squash`). Confirmed entries commit in order through a valid/ready port; misspeculated entries are zeroed and flushed together with everything younger. Speculative data never reaches the commit outputs. The block sits between the speculative producer and the low-label consumer of `final_data`-style state.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- TAG_W, 4, tag width
- DATA_W, 8, data width
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  producer offers a speculative entry
- alloc_ready  out  1  entry accepted when valid&&ready at posedge
- alloc_tag  in  TAG_W  tag of offered entry
- alloc_data  in  DATA_W  speculative payload
- l_valid  in  1  resolution event this cycle
- l_status  in  TAG_W  tag being resolved
- l_squash  in  1  1 = misspeculated, 0 = confirmed
- commit_valid  out  1  head entry is confirmed
- commit_ready  in  1  consumer takes head
- commit_data  out  DATA_W  head payload; 0 whenever commit_valid=0
- commit_tag  out  TAG_W  head tag; 0 whenever commit_valid=0
- busy  out  1  any entry not FREE
- squash_cnt  out  8  saturating squash-event counter (see Configuration)

## Operation
- Per-entry state: FREE, SPEC, SAFE. Circular buffer; head = oldest, tail = next free; count width clog2(DEPTH)+1; pointers wrap mod DEPTH.
- Alloc: on accept, write tag/data at tail, state SPEC, tail+1.
- alloc_ready = (count<DEPTH) && !(l_valid && l_squash).
- Resolve: search SPEC entries for tag == l_status; the oldest match from head wins. No match (or match only on FREE/SAFE) → ignored, no state change.
  - l_squash=0: matched entry → SAFE.
  - l_squash=1: matched entry and all younger entries → FREE, data cleared to 0; tail := matched index.
- Commit: commit_valid = head state SAFE. On commit_valid&&commit_ready: head → FREE, data cleared, head+1.
- Simultaneous events, all in the same cycle:
  - Commit + squash: both apply. Squash cannot hit a SAFE head.
  - Commit + confirm: both apply.
  - Alloc + confirm: both apply.
  - Alloc + squash: cannot occur, because alloc_ready is low.
  - Resolve in the same cycle as the alloc of the same tag does not match the new entry.
- Full: alloc_ready=0; resolve and commit continue. Empty: commit_valid=0, busy=0.

## Timing
- Reset, asynchronous: all entries FREE with data/tag 0; head=tail=count=0. Outputs: alloc_ready=1, commit_valid=0, commit_data=0, commit_tag=0, busy=0, squash_cnt=0.
- rst_n low mid-operation discards all entries immediately. No commit occurs in the reset cycle.
- Entry becomes resolvable the cycle after alloc.
- commit_valid rises the cycle after the confirming resolve. It is driven from registered state, with no combinational path from l_* to commit_*.
- Minimum latency: alloc at cycle 0, confirm at 1, commit_valid at 2.
- Throughput: one alloc, one resolve and one commit per cycle.
- commit_valid holds with stable data until accepted.

## Configuration
- SPEC_SQUASH_CNT_EN defined: squash_cnt increments by 1 per resolve with l_squash=1 that matches a SPEC entry, saturating at 255.
- SPEC_SQUASH_CNT_EN not defined: squash_cnt tied to 0 and no counter register exists.

## Structure
- Package spec_ctrl_pkg holds:
  - entry-state enum (FREE/SPEC/SAFE)
  - entry struct typedef (state, tag, data)
  - default DEPTH/TAG_W/DATA_W constants
- Sub-module spec_tag_match: combinational age-ordered lookup. Inputs are the entry array, head and l_status; outputs are hit and oldest matching SPEC index.

## Test plan
- After reset:
  - alloc tags 1,2,3 (data 0x11,0x22,0x33)
  - confirm 2, then 1
  - commit_ready=1
  → commit order 0x11 then 0x22; tag 3 is held while SPEC; commit_data=0 between commits.
- Alloc tags 1..4 → alloc_ready=0 when full. Then squash tag 2 → tags 2,3,4 freed; tail=1 (mod 4); count=1; next alloc lands in the freed slot.
- Resolve tag 7 (not present), with l_squash both 0 and 1 → no state change; squash_cnt unchanged.
- Pointer wrap: 10 alloc/confirm/commit rounds at DEPTH=4 → in-order data with no loss across wrap.
- Same-cycle confirm of tag 5 and commit of SAFE head tag 4, with commit_ready=1 → tag 4 commits this cycle; tag 5 commit_valid next cycle.
- rst_n pulsed low with 3 entries live → busy=0 and commit_valid=0 immediately. With SPEC_SQUASH_CNT_EN, 300 squash events → squash_cnt=255.
